// File: rtl/tpi_link_pkg.sv
// Shared types and defaults for the TPI drive-side link engine.
package tpi_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_RX_WAIT_LOW = 2'd1,
        ST_TX_PRESENT  = 2'd2,
        ST_TX_WAIT_LOW = 2'd3
    } link_state_e;

    localparam int SYNC_STAGES     = 2;
    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_TIMEOUT = 4095;

endpackage

// File: rtl/tpi_link_engine_fifo.sv
// Synchronous show-ahead byte FIFO; full/empty reflect the count before this cycle's operation.
module link_fifo
    import tpi_link_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every comb output is assigned unconditionally here, so no latch can be inferred.
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count gates every read, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/tpi_link_engine.sv
// Drive-side four-phase strobe/ack byte engine for the TPI port, with RX and TX byte FIFOs.
module tpi_link_engine
    import tpi_link_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pa_in,
    output logic [7:0] pa_out,
    output logic       pa_oe,
    input  logic       strobe_in,
    output logic       ack_out,
    input  logic       mode_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       timeout,
    input  logic       err_clr,
    output logic       busy
);

    logic [SYNC_STAGES-1:0] strobe_sync_q, strobe_sync_d, mode_sync_q, mode_sync_d;
    logic                   strobe_s, mode_s;
    link_state_e            state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [7:0]             pa_out_q, pa_out_d;
    logic                   ack_q, ack_d, pa_oe_q, pa_oe_d;
    logic                   timeout_q, timeout_d, busy_q, busy_d;
    logic                   rx_push, rx_full, rx_empty;
    logic                   tx_pop, tx_full, tx_empty;
    logic [7:0]             tx_head;
    logic                   expired, fire;

    assign strobe_sync_d = {strobe_sync_q[SYNC_STAGES-2:0], strobe_in};
    assign mode_sync_d   = {mode_sync_q[SYNC_STAGES-2:0], mode_in};
    assign strobe_s      = strobe_sync_q[SYNC_STAGES-1];
    assign mode_s        = mode_sync_q[SYNC_STAGES-1];
    assign expired       = (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT));

    link_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .push_data(pa_in),
        .pop(rx_valid && rx_ready), .head(rx_data), .full(rx_full), .empty(rx_empty)
    );

    link_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_valid), .push_data(tx_data),
        .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
    );

    assign rx_valid = !rx_empty;
    assign tx_ready = !tx_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_sync_q <= '0;
            mode_sync_q   <= '0;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            pa_out_q      <= '0;
            ack_q         <= 1'b0;
            pa_oe_q       <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            strobe_sync_q <= strobe_sync_d;
            mode_sync_q   <= mode_sync_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pa_out_q      <= pa_out_d;
            ack_q         <= ack_d;
            pa_oe_q       <= pa_oe_d;
            timeout_q     <= timeout_d;
            busy_q        <= busy_d;
        end
    end

    // Mode is only looked at in IDLE, so a mode flip mid-transfer waits for the transfer to end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!mode_s) begin
                    if (strobe_s && !rx_full) state_d = ST_RX_WAIT_LOW;
                end else if (!tx_empty && !strobe_s) begin
                    state_d = ST_TX_PRESENT;
                end
            end
            ST_RX_WAIT_LOW: if (!strobe_s || expired) state_d = ST_IDLE;
            ST_TX_PRESENT:  if (strobe_s) state_d = ST_TX_WAIT_LOW;
            ST_TX_WAIT_LOW: if (!strobe_s || expired) state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    // The counter holds zero except while dwelling in a wait-low state, which clears it on every entry.
    always_comb begin
        ack_d    = ack_q;
        pa_oe_d  = pa_oe_q;
        pa_out_d = pa_out_q;
        rx_push  = 1'b0;
        tx_pop   = 1'b0;
        fire     = 1'b0;
        cnt_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (!mode_s && strobe_s && !rx_full) begin
                    rx_push = 1'b1;
                    ack_d   = 1'b1;
                end else if (mode_s && !tx_empty && !strobe_s) begin
                    pa_out_d = tx_head;
                    pa_oe_d  = 1'b1;
                    ack_d    = 1'b1;
                end
            end
            ST_TX_PRESENT: begin
                if (strobe_s) begin
                    tx_pop  = 1'b1;
                    ack_d   = 1'b0;
                    pa_oe_d = 1'b0;
                end
            end
            default: begin
                if (!strobe_s) begin
                    ack_d = 1'b0;
                end else if (expired) begin
                    fire    = 1'b1;
                    ack_d   = 1'b0;
                    pa_oe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
        timeout_d = fire ? 1'b1 : (err_clr ? 1'b0 : timeout_q);
        busy_d    = (state_d != ST_IDLE);
    end

    assign pa_out  = pa_out_q;
    assign pa_oe   = pa_oe_q;
    assign ack_out = ack_q;
    assign timeout = timeout_q;
    assign busy    = busy_q;

endmodule
